// File: rtl/serial_rx_sequencer.sv
// Control FSM for the serial receive datapath: hunts for a 4-bit start pattern,
// clears the counter/shift register, shifts 8 bits, then offers the byte via valid/ready.
module serial_rx_sequencer #(
  parameter logic [3:0] PATTERN     = 4'b1101,
  parameter int         FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   abort,
  input  logic                   ser_in,
  input  logic                   co,
  input  logic                   out_ready,
  output logic                   iz0,
  output logic                   cen,
  output logic                   shen,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   match,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [1:0]             state_dbg
);

  // Handshake: a byte is transferred on any cycle where out_valid and out_ready are
  // both high; out_valid never drops before that except on abort or rst.
  typedef enum logic [1:0] {
    ST_DETECT = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_VALID  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             hist_q, hist_d;
  logic [1:0]             hcnt_q, hcnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   cen_q, cen_d;
  logic                   shen_q, shen_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   detect_hit;

  assign detect_hit = (state_q == ST_DETECT) && en && (hcnt_q == 2'd3) &&
                      ({hist_q, ser_in} == PATTERN);

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    hcnt_d      = hcnt_q;
    frame_cnt_d = frame_cnt_q;
    if (abort) begin
      state_d = ST_DETECT;
      hist_d  = 3'd0;
      hcnt_d  = 2'd0;
    end else begin
      case (state_q)
        ST_DETECT: begin
          if (en) begin
            hist_d = {hist_q[1:0], ser_in};
            hcnt_d = (hcnt_q == 2'd3) ? 2'd3 : hcnt_q + 2'd1;
          end
          if (detect_hit) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          // co marks the 8th shift edge; the datapath was cleared by iz0 on match.
          if (co) state_d = ST_VALID;
        end
        ST_VALID: begin
          if (out_ready) begin
            frame_cnt_d = frame_cnt_q + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
            hist_d      = 3'd0;
            hcnt_d      = 2'd0;
            state_d     = ST_DETECT;
          end
        end
        default: state_d = ST_DETECT;
      endcase
    end
    cen_d       = (state_d == ST_SHIFT);
    shen_d      = (state_d == ST_SHIFT);
    out_valid_d = (state_d == ST_VALID);
    busy_d      = (state_d != ST_DETECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_DETECT;
      hist_q      <= 3'd0;
      hcnt_q      <= 2'd0;
      frame_cnt_q <= '0;
      cen_q       <= 1'b0;
      shen_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      hcnt_q      <= hcnt_d;
      frame_cnt_q <= frame_cnt_d;
      cen_q       <= cen_d;
      shen_q      <= shen_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // abort must silence the datapath strobes and valid in the very cycle it is seen.
  assign match     = detect_hit && !abort;
  assign iz0       = abort || match;
  assign cen       = cen_q && !abort;
  assign shen      = shen_q && !abort;
  assign out_valid = out_valid_q && !abort;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_rx_sequencer.sv
// Bench for serial_rx_sequencer: a small counter/shift-register datapath model closes the
// loop, a sample-queue reference model is compared every cycle, plus directed literal checks.
module tb_serial_rx_sequencer;

  localparam logic [3:0] PAT = 4'b1101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, abort = 1'b0, ser_in = 1'b0, out_ready = 1'b0;
  logic       co;
  logic       iz0, cen, shen, out_valid, busy, match;
  logic [7:0] frame_cnt;
  logic [1:0] state_dbg;

  logic [2:0] dp_cnt;
  logic [7:0] dp_par;

  int checks = 0;
  int errors = 0;
  int frames_done = 0;

  serial_rx_sequencer #(.PATTERN(PAT), .FRAME_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .abort(abort), .ser_in(ser_in), .co(co),
    .out_ready(out_ready), .iz0(iz0), .cen(cen), .shen(shen), .out_valid(out_valid),
    .busy(busy), .match(match), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- datapath stand-in ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_cnt <= 3'd0;
      dp_par <= 8'd0;
    end else if (iz0) begin
      dp_cnt <= 3'd0;
      dp_par <= 8'd0;
    end else begin
      if (cen)  dp_cnt <= dp_cnt + 3'd1;
      if (shen) dp_par <= {ser_in, dp_par[7:1]};
    end
  end
  assign co = (dp_cnt == 3'd7);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  int   m_phase;     // 0 hunting, 1 receiving, 2 offering
  int   m_frames;
  logic mhist[$];    // enabled samples since last clear (last 3 kept)
  logic mcap[$];     // bits received in the current frame
  logic [7:0] exp_q[$];
  logic [3:0] pat4;
  logic e_match, e_shen, e_valid, e_busy;
  logic [7:0] e_byte;

  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0; m_frames = 0; mhist.delete(); mcap.delete(); exp_q.delete();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_shen", shen, 1'b0);
      chk("rst_frame_cnt", frame_cnt, 8'd0);
    end else begin
      e_match = 1'b0;
      if (m_phase == 0 && en && !abort && mhist.size() >= 3) begin
        pat4 = {mhist[mhist.size()-3], mhist[mhist.size()-2], mhist[mhist.size()-1], ser_in};
        e_match = (pat4 == PAT);
      end
      e_shen  = (m_phase == 1) && !abort;
      e_valid = (m_phase == 2) && !abort;
      e_busy  = (m_phase != 0);
      chk("match", match, e_match);
      chk("iz0", iz0, abort || e_match);
      chk("cen", cen, e_shen);
      chk("shen", shen, e_shen);
      chk("out_valid", out_valid, e_valid);
      chk("busy", busy, e_busy);
      chk("frame_cnt", frame_cnt, m_frames[7:0]);
      chk("exclusive_strobes", (32'(iz0) + 32'(shen) + 32'(out_valid)) <= 1, 1'b1);
      if (e_valid && exp_q.size() > 0) chk("par_out", dp_par, exp_q[0]);
      if (abort) begin
        m_phase = 0; mhist.delete(); exp_q.delete();
      end else begin
        case (m_phase)
          0: begin
            if (en) begin
              mhist.push_back(ser_in);
              if (mhist.size() > 3) void'(mhist.pop_front());
            end
            if (e_match) begin m_phase = 1; mcap.delete(); end
          end
          1: begin
            mcap.push_back(ser_in);
            if (mcap.size() == 8) begin
              e_byte = 8'd0;
              foreach (mcap[i]) e_byte[i] = mcap[i];
              exp_q.push_back(e_byte);
              m_phase = 2;
            end
          end
          default: begin
            if (out_ready) begin
              m_frames = (m_frames + 1) % 256;
              mhist.delete(); exp_q.delete();
              m_phase = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic e, input logic s, input logic a, input logic r);
    en = e; ser_in = s; abort = a; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic step_m(input logic e, input logic s, input logic exp_m);
    en = e; ser_in = s; abort = 1'b0; out_ready = 1'b0;
    #2 chk("match_lit", match, exp_m);
    @(posedge clk); #1;
  endtask

  task automatic send_pattern();
    for (int i = 3; i >= 0; i--) step_m(1'b1, PAT[i], i == 0);
  endtask

  task automatic shift_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      chk("shen_lit", shen, 1'b1);
      step(1'($urandom_range(0, 1)), d[i], 1'b0, 1'b0);
    end
  endtask

  task automatic handshake(input logic [7:0] d, input int stall);
    for (int k = 0; k < stall; k++) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_par", dp_par, d);
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    chk("hs_valid", out_valid, 1'b1);
    chk("hs_par", dp_par, d);
    step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    frames_done = (frames_done + 1) % 256;
    chk("hs_frame_cnt", frame_cnt, frames_done[7:0]);
    chk("hs_idle", busy, 1'b0);
  endtask

  task automatic run_stream(input logic [15:0] bits, input logic [15:0] ens,
                            input logic [15:0] mpos, input int n);
    for (int i = 0; i < n; i++) step_m(ens[i], bits[i], mpos[i]);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] rb;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", state_dbg, 2'd0);
    chk("reset_valid", out_valid, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // basic frame: data 1,0,1,0,0,1,1,0 lands as 8'h65
    send_pattern();
    shift_byte(8'h65);
    chk("basic_par", dp_par, 8'h65);
    handshake(8'h65, 0);
    chk("basic_frames", frame_cnt, 8'd1);

    // backpressure: 5 stalled cycles, valid held 6 cycles
    send_pattern();
    shift_byte(8'h65);
    handshake(8'h65, 5);
    chk("bp_frames", frame_cnt, 8'd2);

    // overlap 1,1,1,0,1 and partial 1,1,0,0,1,1,0,1
    run_stream(16'h0017, 16'hFFFF, 16'h0010, 5);
    shift_byte(8'hA5);
    handshake(8'hA5, 1);
    run_stream(16'h00B3, 16'hFFFF, 16'h0080, 8);
    shift_byte(8'h3C);
    handshake(8'h3C, 0);

    // enable gating: disabled 1101 ignored, history frozen across the gap
    run_stream(16'h00B7, 16'h00E1, 16'h0080, 8);
    shift_byte(8'hF0);
    handshake(8'hF0, 2);

    // abort on the 4th shift cycle
    send_pattern();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    en = 1'b1; ser_in = 1'b1; abort = 1'b1; out_ready = 1'b0;
    #2 chk("abort_iz0", iz0, 1'b1);
    chk("abort_shen", shen, 1'b0);
    @(posedge clk); #1;
    chk("abort_par", dp_par, 8'd0);
    chk("abort_state", state_dbg, 2'd0);
    chk("abort_frames", frame_cnt, frames_done[7:0]);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // abort with out_ready in the offer phase: not counted
    send_pattern();
    shift_byte(8'h5A);
    en = 1'b1; ser_in = 1'b0; abort = 1'b1; out_ready = 1'b1;
    #2 chk("abort_v_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("abort_v_frames", frame_cnt, frames_done[7:0]);
    chk("abort_v_busy", busy, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // async reset mid-shift
    send_pattern();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("amid_shen", shen, 1'b0);
    chk("amid_cen", cen, 1'b0);
    chk("amid_busy", busy, 1'b0);
    chk("amid_valid", out_valid, 1'b0);
    chk("amid_frames", frame_cnt, 8'd0);
    chk("amid_state", state_dbg, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    frames_done = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // 256 frames: counter wraps 255 -> 0
    for (int f = 0; f < 255; f++) begin
      rb = 8'($urandom_range(0, 255));
      send_pattern();
      shift_byte(rb);
      handshake(rb, $urandom_range(0, 1));
    end
    chk("wrap_255", frame_cnt, 8'd255);
    send_pattern();
    shift_byte(8'h81);
    handshake(8'h81, 0);
    chk("wrap_0", frame_cnt, 8'd0);

    step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
